// File: rtl/instr_encoder.sv
// MIPS instruction encoder feeding instruction memory through a small word FIFO.
// Optional ENC_JUMP_EN macro enables kind 4 (j) encoding.
module instr_encoder #(
    parameter int unsigned             DEPTH     = 4,
    parameter int unsigned             ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       wr_count,
    output logic              err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              push;
    logic              push_word;
    logic              pop;

    // Encode the request; the FIFO only ever holds finished words
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (in_kind)
            3'd0: enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, in_funct};
            3'd1: enc_word = {6'h23, in_rs, in_rt, in_imm};
            3'd2: enc_word = {6'h2B, in_rs, in_rt, in_imm};
            3'd3: enc_word = {6'h04, in_rs, in_rt, in_imm};
`ifdef ENC_JUMP_EN
            3'd4: enc_word = {6'h02, in_rs, in_rt, in_imm};
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign imem_we    = (count_q != '0);
    assign imem_wdata = mem_q[rd_ptr_q];
    assign imem_addr  = addr_q;
    assign wr_count   = wr_count_q;
    assign err        = err_q;

    assign push      = in_valid && in_ready;
    assign push_word = push && enc_legal;
    assign pop       = imem_we && imem_ready;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wr_count_d = wr_count_q;
        err_d      = err_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            addr_d     = BASE_ADDR;
            wr_count_d = '0;
            err_d      = 1'b0;
        end else begin
            if (push_word) begin
                mem_d[wr_ptr_q] = enc_word;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                addr_d     = addr_q + ADDR_W'(1);
                wr_count_d = wr_count_q + 16'(1);
            end
            if (push && !enc_legal) begin
                err_d = 1'b1;
            end
            count_d = count_q + CNT_W'(push_word) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= BASE_ADDR;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wr_count_q <= wr_count_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic vs a queue model.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, imem_ready;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;

    logic        in_ready, imem_we, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] wr_count;

    logic        in_ready2, imem_we2, err2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [15:0] wr_count2;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_q[$];
    int          m_writes = 0;
    logic        m_err = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .wr_count(wr_count), .err(err)
    );

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(2), .BASE_ADDR(2'b00)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
        .in_imm(in_imm), .imem_we(imem_we2), .imem_ready(imem_ready), .imem_addr(imem_addr2),
        .imem_wdata(imem_wdata2), .wr_count(wr_count2), .err(err2)
    );

    function automatic bit kind_legal(input logic [2:0] k);
`ifdef ENC_JUMP_EN
        return k <= 3'd4;
`else
        return k <= 3'd3;
`endif
    endfunction

    function automatic logic [31:0] enc(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
        int unsigned op;
        int unsigned w;
        case (k)
            3'd1: op = 32'h23;
            3'd2: op = 32'h2B;
            3'd3: op = 32'h04;
            3'd4: op = 32'h02;
            default: op = 0;
        endcase
        w = op * 32'h0400_0000 + int'(rs) * 32'h0020_0000 + int'(rt) * 32'h0001_0000;
        if (k == 3'd0) w = w + int'(rd) * 2048 + int'(f);
        else           w = w + int'(imm);
        return w;
    endfunction

    task automatic set_req(input logic v, input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] f, input logic [15:0] imm);
        in_valid = v; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_funct = f; in_imm = imm;
    endtask

    task automatic set_rand_req(input logic v, input bit legal_only);
        logic [2:0] k;
        k = legal_only ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        set_req(v, k, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom));
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic step();
        bit acc, pop;
        @(posedge clk);
        acc = in_valid && (m_q.size() < DEPTH);
        pop = imem_ready && (m_q.size() > 0);
        if (!rst_n || flush) begin
            m_q.delete();
            m_writes = 0;
            m_err = 1'b0;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_writes++;
            end
            if (acc) begin
                if (kind_legal(in_kind)) m_q.push_back(enc(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm));
                else m_err = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_flush();
        flush = 1'b1; in_valid = 1'b0;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; imem_ready = 1'b0;
        set_req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0);
        step(); step();
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (imem_we !== 1'b0)     begin errors++; $display("FAIL reset_we got %0b exp 0", imem_we); end
        checks++; if (imem_addr !== 8'h00)  begin errors++; $display("FAIL reset_addr got %0h exp 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %08h exp 0", imem_wdata); end
        checks++; if (wr_count !== 16'h0)   begin errors++; $display("FAIL reset_wr_count got %0d exp 0", wr_count); end
        checks++; if (err !== 1'b0)         begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    endtask

    task automatic test_rtype();
        imem_ready = 1'b1;
        set_req(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0);
        step();
        in_valid = 1'b0;
        checks++; if (imem_we !== 1'b1)            begin errors++; $display("FAIL rtype_we got %0b exp 1", imem_we); end
        checks++; if (imem_wdata !== 32'h00221820) begin errors++; $display("FAIL rtype_wdata got %08h exp 00221820", imem_wdata); end
        checks++; if (imem_addr !== 8'h00)         begin errors++; $display("FAIL rtype_addr got %0h exp 0", imem_addr); end
        step();
        checks++; if (wr_count !== 16'd1)          begin errors++; $display("FAIL rtype_wr_count got %0d exp 1", wr_count); end
        checks++; if (imem_we !== 1'b0)            begin errors++; $display("FAIL rtype_drained_we got %0b exp 0", imem_we); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h8C080004; exp_w[1] = 32'hAC080008; exp_w[2] = 32'h1109FFFF;
        do_flush();
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_req(1'b1, 3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0004);
                1: set_req(1'b1, 3'd2, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0008);
                default: set_req(1'b1, 3'd3, 5'd8, 5'd9, 5'd0, 6'd0, 16'hFFFF);
            endcase
            step();
            checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL b2b_we[%0d] got %0b exp 1", i, imem_we); end
            checks++; if (imem_wdata !== exp_w[i]) begin errors++; $display("FAIL b2b_wdata[%0d] got %08h exp %08h", i, imem_wdata, exp_w[i]); end
            checks++; if (imem_addr !== 8'(i)) begin errors++; $display("FAIL b2b_addr[%0d] got %0d exp %0d", i, imem_addr, i); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (wr_count !== 16'd3) begin errors++; $display("FAIL b2b_wr_count got %0d exp 3", wr_count); end
    endtask

    task automatic test_full();
        logic [31:0] exp_w [5];
        logic [31:0] got[$];
        int budget;
        do_flush();
        imem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_rand_req(1'b1, 1'b1);
            exp_w[i] = enc(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm);
            step();
            checks++; if (in_ready !== (i < 3)) begin errors++; $display("FAIL full_in_ready[%0d] got %0b exp %0b", i, in_ready, i < 3); end
        end
        checks++; if (imem_wdata !== exp_w[0]) begin errors++; $display("FAIL full_stable_wdata got %08h exp %08h", imem_wdata, exp_w[0]); end
        checks++; if (imem_addr !== 8'h00 || imem_we !== 1'b1) begin errors++; $display("FAIL full_stable_addr got %0h/%0b exp 0/1", imem_addr, imem_we); end
        imem_ready = 1'b1;
        budget = 0;
        while (got.size() < 5 && budget < 20) begin
            bit taken;
            if (imem_we && imem_ready) got.push_back(imem_wdata);
            taken = in_valid && in_ready;
            step();
            if (taken) in_valid = 1'b0;
            if (budget == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0b exp 1", in_ready); end
            end
            budget++;
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL full_drain_timeout got %0d words exp 5", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            checks++; if (got[i] !== exp_w[i]) begin errors++; $display("FAIL full_order[%0d] got %08h exp %08h", i, got[i], exp_w[i]); end
        end
        checks++; if (wr_count !== 16'd5) begin errors++; $display("FAIL full_wr_count got %0d exp 5", wr_count); end
    endtask

    task automatic test_wrap();
        do_flush();
        imem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_rand_req(1'b1, 1'b1);
            step();
            checks++; if (imem_addr2 !== 2'(i % 4)) begin errors++; $display("FAIL wrap_addr2[%0d] got %0d exp %0d", i, imem_addr2, i % 4); end
            checks++; if (imem_addr !== 8'(i)) begin errors++; $display("FAIL wrap_addr[%0d] got %0d exp %0d", i, imem_addr, i); end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_illegal();
        do_flush();
        imem_ready = 1'b1;
        set_req(1'b1, 3'd6, 5'd3, 5'd4, 5'd5, 6'd6, 16'h1234);
        step();
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL illegal_we got %0b exp 0", imem_we); end
        checks++; if (err !== 1'b1)     begin errors++; $display("FAIL illegal_err got %0b exp 1", err); end
        for (int i = 0; i < 4; i++) begin
            set_rand_req(1'b1, 1'b1);
            step();
        end
        in_valid = 1'b0;
        step();
        checks++; if (err !== 1'b1 || wr_count !== 16'd4) begin errors++; $display("FAIL illegal_sticky got err=%0b cnt=%0d exp err=1 cnt=4", err, wr_count); end
        do_flush();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_flush_err got %0b exp 0", err); end
        set_req(1'b1, 3'd4, 5'h1F, 5'd0, 5'd0, 6'd0, 16'h0);
        step();
        in_valid = 1'b0;
`ifdef ENC_JUMP_EN
        checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h0BE00000) begin errors++; $display("FAIL jump_word got we=%0b %08h exp we=1 0BE00000", imem_we, imem_wdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL jump_err got %0b exp 0", err); end
`else
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL kind4_we got %0b exp 0", imem_we); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL kind4_err got %0b exp 1", err); end
`endif
        step();
    endtask

    task automatic test_flush_reset();
        for (int mode = 0; mode < 2; mode++) begin
            do_flush();
            imem_ready = 1'b1;
            set_rand_req(1'b1, 1'b1); step();
            set_req(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0); step();
            imem_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                set_rand_req(1'b1, 1'b1); step();
            end
            set_rand_req(1'b1, 1'b1);
            if (mode == 0) flush = 1'b1; else rst_n = 1'b0;
            step();
            flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
            checks++; if (imem_we !== 1'b0)    begin errors++; $display("FAIL restart%0d_we got %0b exp 0", mode, imem_we); end
            checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL restart%0d_addr got %0h exp 0", mode, imem_addr); end
            checks++; if (wr_count !== 16'd0)  begin errors++; $display("FAIL restart%0d_wr_count got %0d exp 0", mode, wr_count); end
            checks++; if (err !== 1'b0)        begin errors++; $display("FAIL restart%0d_err got %0b exp 0", mode, err); end
            checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL restart%0d_in_ready got %0b exp 1", mode, in_ready); end
            step();
            checks++; if (imem_we !== 1'b0)    begin errors++; $display("FAIL restart%0d_no_push got %0b exp 0", mode, imem_we); end
        end
    endtask

    task automatic test_random();
        do_flush();
        for (int c = 0; c < 500; c++) begin
            set_rand_req(1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
            imem_ready = 1'($urandom_range(0, 2) != 0);
            flush = 1'($urandom_range(0, 59) == 0);
            step();
            flush = 1'b0;
            checks++; if (in_ready !== (m_q.size() < DEPTH)) begin errors++; $display("FAIL rnd_in_ready c=%0d got %0b exp %0b", c, in_ready, m_q.size() < DEPTH); end
            checks++; if (imem_we !== (m_q.size() > 0)) begin errors++; $display("FAIL rnd_we c=%0d got %0b exp %0b", c, imem_we, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                checks++; if (imem_wdata !== m_q[0]) begin errors++; $display("FAIL rnd_wdata c=%0d got %08h exp %08h", c, imem_wdata, m_q[0]); end
            end
            checks++; if (imem_addr !== 8'(m_writes) || imem_addr2 !== 2'(m_writes)) begin errors++; $display("FAIL rnd_addr c=%0d got %0d/%0d exp %0d", c, imem_addr, imem_addr2, m_writes); end
            checks++; if (wr_count !== 16'(m_writes)) begin errors++; $display("FAIL rnd_wr_count c=%0d got %0d exp %0d", c, wr_count, m_writes); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err c=%0d got %0b exp %0b", c, err, m_err); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_full();
        test_wrap();
        test_illegal();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
